// File: rtl/exec_pkg.sv
// exec_pkg -- shared definitions for the inst_exec_core codebase slice.
// Holds the instruction field positions, the M/D opcode codes, the address
// of the memory-mapped Tx port and the core state encoding.
package exec_pkg;

  localparam int PC_W   = 4;
  localparam int INST_W = 10;
  localparam int ADDR_W = 5;

  // Instruction field positions
  localparam int M_HI    = 9;
  localparam int M_LO    = 8;
  localparam int D_HI    = 7;
  localparam int D_LO    = 6;
  localparam int S_BIT   = 5;
  localparam int SUB_BIT = 2;
  localparam int IMM_HI  = 3;
  localparam int IMM_LO  = 0;
  localparam int ADDR_HI = 4;
  localparam int ADDR_LO = 0;

  // M codes (mode); M=11 is both memory access (S=1) and jump-if-zero (S=0)
  localparam logic [1:0] M_ALU = 2'b00;
  localparam logic [1:0] M_JC  = 2'b01;
  localparam logic [1:0] M_JMP = 2'b10;
  localparam logic [1:0] M_MEM = 2'b11;
  localparam logic [1:0] M_JZ  = 2'b11;

  // D codes (destination); D=11 is store (S=1) or jump (S=0)
  localparam logic [1:0] D_RA = 2'b00;
  localparam logic [1:0] D_RB = 2'b01;
  localparam logic [1:0] D_RO = 2'b10;
  localparam logic [1:0] D_ST = 2'b11;

  localparam logic [ADDR_W-1:0] TX_ADDR = 5'd16;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_TX_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } exec_state_e;

endpackage

// File: rtl/exec_dmem.sv
// exec_dmem -- data memory for inst_exec_core.
// One synchronous write port and one combinational read port, DEPTH words
// at addresses 0..DEPTH-1. Addresses at or above DEPTH read as zero and
// writes to them are dropped. Contents are not reset.
// Ports:
//   clk     : clock, write on rising edge
//   we_i    : write enable
//   waddr_i : write address (5-bit store address space)
//   wdata_i : write data
//   raddr_i : read address (5-bit load address space)
//   rdata_o : read data, combinational
module exec_dmem
  import exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              rd_hit;
  logic              wr_hit;

  assign rd_hit = (int'(raddr_i) < DEPTH);
  assign wr_hit = (int'(waddr_i) < DEPTH);

  always_ff @(posedge clk) begin
    if (we_i && wr_hit) begin
      mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = rd_hit ? mem_q[raddr_i[IDX_W-1:0]] : '0;

endmodule

// File: rtl/inst_exec_core.sv
// inst_exec_core -- single-cycle instruction execution core with a
// memory-mapped, ready/valid Tx port.
// One instruction per cycle from a combinational program ROM; a store to the
// Tx address stalls in TX_WAIT until the sink accepts the byte.
// Optional feature: define EXEC_HALT_DETECT_EN to make an unconditional jump
// to the current pc enter a HALT state (halted=1, everything frozen until
// reset). Without it the jump simply loops and halted is tied low.
// Ports:
//   clk      : clock
//   rst_n    : synchronous active-low reset
//   pc       : program ROM address
//   inst     : instruction at pc (same cycle)
//   tx_data  : Tx byte, stable while tx_valid=1
//   tx_valid : Tx byte valid
//   tx_ready : Tx sink accepts
//   ro       : output register Ro
//   halted   : core stopped
module inst_exec_core
  import exec_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DMEM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] inst,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] ro,
  output logic              halted
);

  exec_state_e       state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [DATA_W-1:0] ra_q, ra_d, rb_q, rb_d, ro_q, ro_d, txd_q, txd_d;
  logic              c_q, c_d, z_q, z_d, txv_q, txv_d;

  logic [1:0]        m_f, d_f;
  logic              s_f, sub_f;
  logic [PC_W-1:0]   imm_f;
  logic [ADDR_W-1:0] addr_f;

  logic              is_alu, is_ldi, is_mov, is_ld, is_st, is_jmp;
  logic              jmp_take, st_tx, reg_we, dmem_we;
  logic [DATA_W:0]   alu_res;
  logic [DATA_W-1:0] reg_wval, dmem_rdata;

  // Carry of a+b, or of a+~b+1 for subtract (carry=1 means no borrow).
  function automatic logic [DATA_W:0] addsub(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic              sub);
    logic [DATA_W-1:0] bb;
    bb = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + (DATA_W+1)'(sub);
  endfunction

  // ---- decode ----
  assign m_f    = inst[M_HI:M_LO];
  assign d_f    = inst[D_HI:D_LO];
  assign s_f    = inst[S_BIT];
  assign sub_f  = inst[SUB_BIT];
  assign imm_f  = inst[IMM_HI:IMM_LO];
  assign addr_f = inst[ADDR_HI:ADDR_LO];

  assign is_alu = (m_f == M_ALU) && ((d_f == D_RA) || (d_f == D_RB)) && !s_f;
  assign is_ldi = (m_f == M_ALU) && ((d_f == D_RA) || (d_f == D_RB)) &&  s_f;
  assign is_mov = (m_f == M_ALU) && (d_f == D_RO);
  assign is_ld  = (m_f == M_MEM) && ((d_f == D_RA) || (d_f == D_RB)) &&  s_f;
  assign is_st  = (m_f == M_MEM) && (d_f == D_ST) &&  s_f;
  assign is_jmp = (d_f == D_ST) && !s_f;

  assign jmp_take = (m_f == M_JMP) || ((m_f == M_JC) && c_q) || ((m_f == M_JZ) && z_q);
  assign st_tx    = is_st && (addr_f == TX_ADDR);

  assign alu_res = addsub(ra_q, rb_q, sub_f);
  assign reg_we  = is_alu || is_ldi || is_ld;

  always_comb begin
    reg_wval = dmem_rdata;
    if (is_alu) begin
      reg_wval = alu_res[DATA_W-1:0];
    end else if (is_ldi) begin
      reg_wval = DATA_W'(imm_f);
    end
  end

  // Out-of-range store addresses are filtered inside the memory.
  assign dmem_we = (state_q == ST_RUN) && is_st && !st_tx;

  exec_dmem #(
    .DATA_W (DATA_W),
    .DEPTH  (DMEM_DEPTH)
  ) u_dmem (
    .clk     (clk),
    .we_i    (dmem_we),
    .waddr_i (addr_f),
    .wdata_i (ra_q),
    .raddr_i (addr_f),
    .rdata_o (dmem_rdata)
  );

`ifdef EXEC_HALT_DETECT_EN
  logic self_jump;
  assign self_jump = is_jmp && (m_f == M_JMP) && (imm_f == pc_q);
`endif

  // ---- execute / next state ----
  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    ro_d    = ro_q;
    c_d     = c_q;
    z_d     = z_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    case (state_q)
      ST_RUN: begin
        pc_d = pc_inc;
        if (reg_we) begin
          if (d_f == D_RA) begin
            ra_d = reg_wval;
          end else begin
            rb_d = reg_wval;
          end
        end
        if (is_alu) begin
          c_d = alu_res[DATA_W];
          z_d = (alu_res[DATA_W-1:0] == '0);
        end
        if (is_mov) begin
          ro_d = ra_q;
        end
        // Tx store: latch the byte and hold pc on the store until accepted,
        // so the handshake cycle is always a separate cycle.
        if (st_tx) begin
          txd_d   = ra_q;
          txv_d   = 1'b1;
          pc_d    = pc_q;
          state_d = ST_TX_WAIT;
        end
        if (is_jmp && jmp_take) begin
          pc_d = imm_f;
`ifdef EXEC_HALT_DETECT_EN
          if (self_jump) begin
            state_d = ST_HALT;
          end
`endif
        end
      end
      ST_TX_WAIT: begin
        if (txv_q && tx_ready) begin
          txv_d   = 1'b0;
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end
      end
`ifdef EXEC_HALT_DETECT_EN
      ST_HALT: begin
      end
`endif
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // ---- state registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      ro_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      ro_q    <= ro_d;
      c_q     <= c_d;
      z_q     <= z_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
    end
  end

  assign pc       = pc_q;
  assign tx_data  = txd_q;
  assign tx_valid = txv_q;
  assign ro       = ro_q;

`ifdef EXEC_HALT_DETECT_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/inst_exec_core.md
INST_EXEC_CORE -- requirements
Module: inst_exec_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning register/data/Tx width.
REQ-002 SHALL have parameter DMEM_DEPTH, default 16, meaning data-memory words at addresses 0..DMEM_DEPTH-1.
REQ-003 SHALL have ports:
- clk input 1, single clock; all state updates on rising edge.
- rst_n input 1, synchronous active-low reset.
- pc output 4, address to the combinational program ROM.
- inst input 10, instruction returned for pc in the same cycle.
- tx_data output DATA_W, Tx byte.
- tx_valid output 1, Tx byte valid.
- tx_ready input 1, Tx sink accepts.
- ro output DATA_W, output register Ro.
- halted output 1, core stopped (see Configuration).

Function
REQ-004 SHALL execute one instruction per cycle from inst, except during a Tx stall.
REQ-005 SHALL decode fields: M=inst[9:8], D=inst[7:6], S=inst[5], SUB=inst[2], imm4=inst[3:0] zero-extended, addr5=inst[4:0].
REQ-006 M=00, D=00/01, S=0: Ra or Rb (per D) <= Ra+Rb, or Ra-Rb if SUB=1; C <= carry-out (sub: carry of Ra+~Rb+1), Z <= (result==0).
REQ-007 M=00, D=00/01, S=1: Ra or Rb <= imm4; flags unchanged.
REQ-008 M=00, D=10: Ro <= Ra; flags unchanged.
REQ-009 M=11, D=00/01, S=1: Ra or Rb <= dmem[addr5]; addr5 >= DMEM_DEPTH reads 0.
REQ-010 M=11, D=11, S=1: store Ra to addr5; addr5 < DMEM_DEPTH writes dmem; addr5=16 is the Tx port; other addresses are ignored.
REQ-011 D=11, S=0 is a jump to inst[3:0]: M=10 always, M=01 if C=1, M=11 if Z=1; untaken or M=00 advances pc.
REQ-012 All other encodings SHALL be NOPs; pc increments modulo 16 (15 -> 0).
REQ-013 FSM states RUN, TX_WAIT, HALT (HALT only with the macro).
REQ-014 RUN, Tx store: tx_data <= Ra, tx_valid <= 1, go to TX_WAIT; pc holds.
REQ-015 TX_WAIT: while tx_valid=1 and tx_ready=0, tx_data and pc hold; handshake completes on tx_valid & tx_ready, then tx_valid <= 0, pc+1, go to RUN.
REQ-016 tx_data SHALL NOT change while tx_valid=1.
REQ-017 A jump taken and a Tx stall can never coincide; a store to Tx with tx_ready already 1 still costs exactly 2 cycles.

Reset
REQ-018 rst_n=0 at a clock edge SHALL set pc=0, Ra=Rb=Ro=0, C=Z=0, tx_valid=0, tx_data=0, halted=0, state=RUN, aborting any TX_WAIT.
REQ-019 dmem contents SHALL NOT be cleared by reset.

Configuration
REQ-020 With macro EXEC_HALT_DETECT_EN defined, an unconditional jump (M=10) to the current pc enters HALT: halted=1; pc, registers and Tx frozen until reset.
REQ-021 Without EXEC_HALT_DETECT_EN, such a jump loops normally; the HALT state is absent and halted is tied 0.

Structure
REQ-022 A shared package exec_pkg SHALL hold: field position constants, M/D code constants, TX_ADDR=16, and the state enum.
REQ-023 Data memory SHALL be a sub-module exec_dmem: one sync write port and one combinational read port.

Verification
REQ-024 Fibonacci loop (RA=1;[1]=RA;RA=0;[2]=RA;[16]=RA;RA=[1];RB=[2];[16]=RA;[2]=RA;add;JC 0;J 6), tx_ready=1 -> Tx sequence 0,1,1,2,3,5,8,13,21,34,55,89,144,233, then carry restart and 0,1,1...
REQ-025 Same program, tx_ready=0 for 5 cycles on first Tx -> tx_valid held, tx_data=0 stable, pc frozen, resumes on ready.
REQ-026 Ra=3, Rb=3, sub to Ra, JZ 9 -> Ra=0, Z=1, C=1, pc=9 next.
REQ-027 NOP at pc=15 -> pc=0 next cycle.
REQ-028 rst_n=0 during TX_WAIT -> tx_valid=0, pc=0 next cycle.
REQ-029 With EXEC_HALT_DETECT_EN, J 5 at pc=5 -> halted=1, pc stays 5.
